sdam_wfifo: RTL

- Downstream consumer of the serial address/data receiver (SDAM).
- Captures each decoded frame (8-bit address + 16-bit data, signalled by avalid/dvalid) into a small FIFO.
- Presents frames one at a time to a memory/register writer over a valid/ready handshake.
- Also counts frames dropped on overflow and flags receiver protocol anomalies.
- Clocked by the same scl as the receiver, so no clock-domain crossing is needed.

---
 rtl/sdam_wfifo_if.sv | 25 ++
 rtl/sdam_wfifo.sv | 93 +++++++++
 2 files changed

// File: rtl/sdam_wfifo_if.sv
// Write-port handshake between the frame FIFO and the memory/register writer.
// A transfer happens on every scl edge where wr_valid and wr_ready are both high.
interface sdam_wfifo_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/sdam_wfifo.sv
// Captures SDAM receiver frames into a small first-word-fall-through FIFO and
// hands them to a writer; also counts overflow drops and flags avalid/dvalid skew.
module sdam_wfifo #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DROP_W = 8
) (
    input  logic                       scl,
    input  logic                       reset_n,
    input  logic                       avalid,
    input  logic [ADDR_W-1:0]          aout,
    input  logic                       dvalid,
    input  logic [DATA_W-1:0]          dout,
    sdam_wfifo_if.master               wr,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic [DROP_W-1:0]          drop_cnt,
    output logic                       mismatch
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          prev_v;

    logic v;
    logic evt;
    logic pop;
    logic push;
    logic drop;

    // A frame is the rising edge of the joint valid level, so a long
    // valid pulse still yields a single entry.
    assign v    = avalid & dvalid;
    assign evt  = v & ~prev_v;
    assign pop  = wr.wr_valid & wr.wr_ready;
    assign push = evt & (~full | pop);
    assign drop = evt & full & ~pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        wr.wr_valid = ~empty;
        wr.wr_addr  = '0;
        wr.wr_data  = '0;
        if (!empty) begin
            {wr.wr_addr, wr.wr_data} = mem[rd_ptr];
        end
    end

    // Storage is not reset: contents are only visible through rd_ptr when count > 0.
    always_ff @(posedge scl) begin
        if (push) begin
            mem[wr_ptr] <= {aout, dout};
        end
    end

    always_ff @(posedge scl or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            prev_v   <= 1'b0;
            drop_cnt <= '0;
            mismatch <= 1'b0;
        end else begin
            prev_v <= v;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop && (drop_cnt != {DROP_W{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
            if (avalid != dvalid) begin
                mismatch <= 1'b1;
            end
        end
    end
endmodule
